gptp_loopback_delay: RTL and testbench
======================================

# gptp_loopback_delay

Parametrised gPTP loopback delay emulator for the gPTP test path. Accepts transmit frames, echoes a transmit timestamp immediately, and queues up to DEPTH frames in flight. Each frame is released after a run-time-programmable cycle delay with a receive timestamp prepended. It sits between the gPTP TX frame source and the RX parser, standing in for a link with configurable latency and multiple outstanding frames.

## Interface
- FRAME_W, 352, frame payload width
- TS_W, 80, timestamp width ({epoch[15:0], sec[31:0], ns[31:0]}); fixed at 80
- DEPTH, 4, in-flight frame queue depth; power of two, ≥2
- DELAY_W, 32, delay and cycle-counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- delay_cycles  in  DELAY_W  loopback delay in clk cycles; sampled per frame at acceptance
- gptp_ts_vaild  in  1  TX frame valid
- gptp_ts_ready  out  1  queue can accept a frame
- gptp_ts_data  in  FRAME_W  TX frame
- gptp_ts_rv_vaild  out  1  one-cycle pulse: transmit timestamp available
- gptp_ts_rv_data  out  TS_W  transmit timestamp of the last accepted frame
- gptp_rv_vaild  out  1  delayed frame valid
- gptp_rv_ready  in  1  downstream accepts the delayed frame
- gptp_rv_data  out  TS_W+FRAME_W  {rx_timestamp, frame}
- rtc_nanosec_field  in  32  RTC nanoseconds
- rtc_sec_field  in  32  RTC seconds
- rtc_epoch_field  in  16  RTC epoch
- queue_level  out  $clog2(DEPTH)+1  entries in queue; output stage not counted
- frames_sent  out  16  completed output handshakes; wraps at 2^16

## Operation
- Free-running cycle counter `cnt` (DELAY_W bits). Reset value 0; increments every cycle and wraps.
- Accept: a frame is accepted when gptp_ts_vaild && gptp_ts_ready. gptp_ts_ready = (queue_level < DEPTH); the same-cycle pop is not considered.
- On accept, the queue entry stores:
  - the frame;
  - tx_ts = {epoch, sec, ns} sampled at the accept edge;
  - due = cnt + max(delay_cycles, 1), modulo 2^DELAY_W.
- On accept, the tx_ts register also loads tx_ts. gptp_ts_rv_data holds this value until the next accept.
- Maturity: the head entry is mature when (cnt − due), taken as a signed DELAY_W value, is ≥ 0. This compare is wrap-safe. delay_cycles must be < 2^(DELAY_W−1).
- Output stage: a single register. The head moves into it when mature and the stage is empty or completing a handshake this cycle.
  - On that move, rx_ts = RTC sampled at the same edge, and gptp_rv_data = {rx_ts, frame}.
- Output handshake: gptp_rv_vaild never depends on gptp_rv_ready. Data and valid hold stable until gptp_rv_vaild && gptp_rv_ready. frames_sent increments on each handshake.
- Ordering: strict FIFO. A short-delay frame behind a long-delay frame waits for that frame (head-of-line).
- delay_cycles changes affect only frames accepted afterwards.
- Push and pop in the same cycle are both performed; queue_level is unchanged.
- Reset (asynchronous) clears immediately:
  - cnt, queue pointers, queue_level, frames_sent;
  - the output stage;
  - all valids, gptp_ts_rv_data, and gptp_rv_data.
- gptp_ts_ready is 0 while reset is asserted and 1 from the first edge after release. In-flight frames are discarded.

## Timing
- Transmit echo: accept at edge N → gptp_ts_rv_vaild high for exactly cycle N..N+1. Data is valid in the same cycle.
- Release: for a frame accepted at edge N with delay D ≥ 1, empty output stage and no older frames, gptp_rv_vaild rises at edge N+D. The RTC is sampled at edge N+D.
- D = 0 behaves as D = 1.
- Throughput: one frame per cycle in and out when mature and gptp_rv_ready is held high.
- Full: after the DEPTH-th accept, gptp_ts_ready drops at the next edge. It rises again the cycle after the head moves to the output stage.
- Backpressure: a mature head waits in the queue. Its rx_ts is taken when it enters the output stage, not at handshake.

## Test plan
- Single frame: DEPTH=4, D=1000, RTC ns incrementing 1/cycle, accept at ns=100 → gptp_ts_rv_vaild pulse one cycle later with ns=100. gptp_rv_vaild rises 1000 cycles after accept with rx ns=1100 and frame bits unchanged. frames_sent=1 after the handshake.
- Full queue: D=50, 6 back-to-back frames, gptp_rv_ready=1 → 4 accepted, ready low with queue_level=4. Frame 1 moves to the output stage and frame 5 is accepted. Outputs appear in order 1..6, each rx_ts ≥ tx_ts+50.
- Backpressure: D=20, gptp_rv_ready=0 for 30 cycles after gptp_rv_vaild rises → gptp_rv_data stable, valid held, second queued frame not lost, rx_ts equals the output-stage entry time.
- Wrap: DELAY_W=8, wait until cnt≈200, D=100 → release exactly 100 cycles after accept across the counter wrap.
- Delay change and head-of-line: frame A at D=100, frame B 5 cycles later at D=10 → B emerges the cycle after A's handshake with ready=1, not earlier.
- Reset mid-flight: 3 frames queued, one valid on output, assert reset asynchronously → gptp_rv_vaild, gptp_ts_rv_vaild, queue_level and frames_sent are 0 immediately. After release: ready=1 and no stale frame ever emerges.

Source files
------------

// File: rtl/gptp_loopback_delay.sv
// gPTP loopback delay emulator: echoes a TX timestamp on accept and releases each
// queued frame after its own programmable delay, prefixed with the RX timestamp.
module gptp_loopback_delay #(
    parameter int FRAME_W = 352,
    parameter int TS_W    = 80,
    parameter int DEPTH   = 4,
    parameter int DELAY_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DELAY_W-1:0]      delay_cycles,
    input  logic                    gptp_ts_vaild,
    output logic                    gptp_ts_ready,
    input  logic [FRAME_W-1:0]      gptp_ts_data,
    output logic                    gptp_ts_rv_vaild,
    output logic [TS_W-1:0]         gptp_ts_rv_data,
    output logic                    gptp_rv_vaild,
    input  logic                    gptp_rv_ready,
    output logic [TS_W+FRAME_W-1:0] gptp_rv_data,
    input  logic [31:0]             rtc_nanosec_field,
    input  logic [31:0]             rtc_sec_field,
    input  logic [15:0]             rtc_epoch_field,
    output logic [$clog2(DEPTH):0]  queue_level,
    output logic [15:0]             frames_sent
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [DELAY_W-1:0] ONE        = DELAY_W'(1);

    logic [DELAY_W-1:0] cnt;
    logic [FRAME_W-1:0] q_frame [DEPTH];
    logic [DELAY_W-1:0] q_due   [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               ready_en;
    logic [TS_W-1:0]    rtc_now;
    logic [DELAY_W-1:0] delay_eff;
    logic [DELAY_W-1:0] head_age;
    logic               head_mature;
    logic               push;
    logic               pop;
    logic               handshake;

    assign rtc_now   = {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field};
    assign delay_eff = (delay_cycles == '0) ? ONE : delay_cycles;

    // Signed difference keeps the maturity test correct across counter wrap.
    assign head_age    = cnt - q_due[rd_ptr];
    assign head_mature = ~head_age[DELAY_W-1];

    assign gptp_ts_ready = ready_en && (queue_level < FULL_LEVEL);
    assign push          = gptp_ts_vaild && gptp_ts_ready;
    assign handshake     = gptp_rv_vaild && gptp_rv_ready;
    assign pop           = (queue_level != '0) && head_mature
                           && (!gptp_rv_vaild || gptp_rv_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            q_frame[wr_ptr] <= gptp_ts_data;
            q_due[wr_ptr]   <= cnt + delay_eff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt              <= '0;
            ready_en         <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            queue_level      <= '0;
            frames_sent      <= '0;
            gptp_ts_rv_vaild <= 1'b0;
            gptp_ts_rv_data  <= '0;
            gptp_rv_vaild    <= 1'b0;
            gptp_rv_data     <= '0;
        end else begin
            cnt              <= cnt + ONE;
            ready_en         <= 1'b1;
            gptp_ts_rv_vaild <= push;
            if (push) begin
                gptp_ts_rv_data <= rtc_now;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   queue_level <= queue_level + 1'b1;
                2'b01:   queue_level <= queue_level - 1'b1;
                default: queue_level <= queue_level;
            endcase
            if (handshake) begin
                frames_sent <= frames_sent + 16'd1;
            end
            // RX timestamp is taken when the frame enters the output stage.
            if (pop) begin
                gptp_rv_vaild <= 1'b1;
                gptp_rv_data  <= {rtc_now, q_frame[rd_ptr]};
            end else if (handshake) begin
                gptp_rv_vaild <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gptp_loopback_delay.sv
// Bench for gptp_loopback_delay: absolute-time queue model checked every cycle,
// a latency vector table, and directed full/backpressure/HOL/wrap/reset sequences.
module tb_gptp_loopback_delay;
    localparam int FRAME_W = 352;
    localparam int TS_W    = 80;
    localparam int DEPTH   = 4;
    localparam int DELAY_W = 32;
    localparam int OUT_W   = TS_W + FRAME_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [DELAY_W-1:0]   delay_cycles;
    logic                 gptp_ts_vaild;
    logic                 gptp_ts_ready;
    logic [FRAME_W-1:0]   gptp_ts_data;
    logic                 gptp_ts_rv_vaild;
    logic [TS_W-1:0]      gptp_ts_rv_data;
    logic                 gptp_rv_vaild;
    logic                 gptp_rv_ready;
    logic [OUT_W-1:0]     gptp_rv_data;
    logic [31:0]          rtc_nanosec_field;
    logic [31:0]          rtc_sec_field;
    logic [15:0]          rtc_epoch_field;
    logic [2:0]           queue_level;
    logic [15:0]          frames_sent;

    // Second instance with an 8-bit counter for the wrap-around case.
    logic [7:0]           w_dly;
    logic                 w_v;
    logic                 w_ready;
    logic                 w_ts_rv_v;
    logic [TS_W-1:0]      w_ts_rv_d;
    logic                 w_rv_v;
    logic                 w_rv_ready;
    logic [OUT_W-1:0]     w_rv_d;
    logic [2:0]           w_level;
    logic [15:0]          w_sent;

    gptp_loopback_delay #(.FRAME_W(FRAME_W), .TS_W(TS_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
        .clk(clk), .reset(reset), .delay_cycles(delay_cycles),
        .gptp_ts_vaild(gptp_ts_vaild), .gptp_ts_ready(gptp_ts_ready), .gptp_ts_data(gptp_ts_data),
        .gptp_ts_rv_vaild(gptp_ts_rv_vaild), .gptp_ts_rv_data(gptp_ts_rv_data),
        .gptp_rv_vaild(gptp_rv_vaild), .gptp_rv_ready(gptp_rv_ready), .gptp_rv_data(gptp_rv_data),
        .rtc_nanosec_field(rtc_nanosec_field), .rtc_sec_field(rtc_sec_field),
        .rtc_epoch_field(rtc_epoch_field), .queue_level(queue_level), .frames_sent(frames_sent)
    );

    gptp_loopback_delay #(.FRAME_W(FRAME_W), .TS_W(TS_W), .DEPTH(DEPTH), .DELAY_W(8)) dut_wrap (
        .clk(clk), .reset(reset), .delay_cycles(w_dly),
        .gptp_ts_vaild(w_v), .gptp_ts_ready(w_ready), .gptp_ts_data(gptp_ts_data),
        .gptp_ts_rv_vaild(w_ts_rv_v), .gptp_ts_rv_data(w_ts_rv_d),
        .gptp_rv_vaild(w_rv_v), .gptp_rv_ready(w_rv_ready), .gptp_rv_data(w_rv_d),
        .rtc_nanosec_field(rtc_nanosec_field), .rtc_sec_field(rtc_sec_field),
        .rtc_epoch_field(rtc_epoch_field), .queue_level(w_level), .frames_sent(w_sent)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute cycle time, queue of {frame, release time}.
    typedef struct {
        logic [FRAME_W-1:0] frame;
        longint             due;
    } ent_t;
    ent_t               q[$];
    longint             m_cnt;
    logic               m_ready_en;
    logic               m_ts_v;
    logic [TS_W-1:0]    m_ts_d;
    logic               m_rv_v;
    logic [OUT_W-1:0]   m_rv_d;
    logic [15:0]        m_sent;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt      = 0;
        m_ready_en = 1'b0;
        m_ts_v     = 1'b0;
        m_ts_d     = '0;
        m_rv_v     = 1'b0;
        m_rv_d     = '0;
        m_sent     = '0;
    endtask

    task automatic model_update();
        logic   rdy, push, hs, pop;
        longint d;
        ent_t   e;
        if (!reset) begin
            model_reset();
            return;
        end
        rdy  = m_ready_en && (q.size() < DEPTH);
        push = gptp_ts_vaild && rdy;
        hs   = m_rv_v && gptp_rv_ready;
        pop  = (q.size() > 0) && (m_cnt >= q[0].due) && (!m_rv_v || gptp_rv_ready);
        if (hs) m_sent++;
        if (pop) begin
            m_rv_v = 1'b1;
            m_rv_d = {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field, q[0].frame};
            void'(q.pop_front());
        end else if (hs) begin
            m_rv_v = 1'b0;
        end
        m_ts_v = push;
        if (push) begin
            d       = (delay_cycles == 0) ? 1 : longint'(delay_cycles);
            m_ts_d  = {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field};
            e.frame = gptp_ts_data;
            e.due   = m_cnt + d;
            q.push_back(e);
        end
        m_cnt++;
        m_ready_en = 1'b1;
    endtask

    task automatic compare();
        chk("ready", gptp_ts_ready, m_ready_en && (q.size() < DEPTH));
        chk("ts_rv_vaild", gptp_ts_rv_vaild, m_ts_v);
        chk("ts_rv_data", gptp_ts_rv_data, m_ts_d);
        chk("rv_vaild", gptp_rv_vaild, m_rv_v);
        if (m_rv_v) chk("rv_data", gptp_rv_data, m_rv_d);
        chk("queue_level", queue_level, q.size());
        chk("frames_sent", frames_sent, m_sent);
    endtask

    // One clock: advance RTC, predict the edge, then compare at the falling edge.
    task automatic step();
        rtc_nanosec_field = rtc_nanosec_field + 32'd1;
        model_update();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int i = 0; i < FRAME_W / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic drain();
        int i;
        gptp_ts_vaild = 1'b0;
        gptp_rv_ready = 1'b1;
        i = 0;
        while ((gptp_rv_vaild || queue_level != 0) && i < 3000) begin
            step();
            i++;
        end
        chk("drained", {gptp_rv_vaild, queue_level}, 0);
    endtask

    typedef struct {
        logic [DELAY_W-1:0] dly;
        int                 exp_lat;
    } vec_t;
    vec_t vecs[6];

    logic [FRAME_W-1:0] fa, fb;
    logic [OUT_W-1:0]   hold;
    logic [31:0]        tx_ns;
    int                 lat, nacc;
    logic               acc;

    initial begin
        vecs = '{'{32'd1000, 1000}, '{32'd0, 1}, '{32'd1, 1}, '{32'd2, 2}, '{32'd50, 50}, '{32'd7, 7}};
        reset = 1'b1;
        delay_cycles = '0; gptp_ts_vaild = 1'b0; gptp_ts_data = '0; gptp_rv_ready = 1'b1;
        rtc_nanosec_field = '0; rtc_sec_field = $urandom; rtc_epoch_field = 16'h1234;
        w_dly = '0; w_v = 1'b0; w_rv_ready = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", gptp_ts_ready, 0);
        chk("rst_ts_rv_vaild", gptp_ts_rv_vaild, 0);
        chk("rst_ts_rv_data", gptp_ts_rv_data, 0);
        chk("rst_rv_vaild", gptp_rv_vaild, 0);
        chk("rst_rv_data", gptp_rv_data, 0);
        chk("rst_level", queue_level, 0);
        chk("rst_sent", frames_sent, 0);
        step();
        #1 reset = 1'b1;
        step();

        // Latency table, including D=0 treated as 1 and a later delay change.
        for (int v = 0; v < 6; v++) begin
            drain();
            fa = rand_frame();
            gptp_ts_data = fa; delay_cycles = vecs[v].dly; gptp_ts_vaild = 1'b1;
            step();
            tx_ns = rtc_nanosec_field;
            gptp_ts_vaild = 1'b0; delay_cycles = 32'd3;
            chk("echo_ns", gptp_ts_rv_data[31:0], tx_ns);
            lat = 0;
            for (int k = 1; k <= 2000 && lat == 0; k++) begin
                step();
                if (gptp_rv_vaild) lat = k;
            end
            chk("latency", lat, vecs[v].exp_lat);
            chk("rx_ns", gptp_rv_data[FRAME_W +: 32], tx_ns + 32'(vecs[v].exp_lat));
            chk("rx_frame", gptp_rv_data[FRAME_W-1:0], fa);
        end

        // Full queue with six back-to-back frames.
        drain();
        delay_cycles = 32'd50; nacc = 0;
        for (int i = 0; i < 300 && nacc < 6; i++) begin
            gptp_ts_vaild = 1'b1; gptp_ts_data = rand_frame();
            acc = gptp_ts_ready;
            step();
            if (acc) nacc++;
            if (acc && nacc == 4) begin
                chk("full_ready", gptp_ts_ready, 0);
                chk("full_level", queue_level, 4);
            end
        end
        gptp_ts_vaild = 1'b0;
        chk("six_accepted", nacc, 6);

        // Backpressure: held output stays stable, second frame survives.
        drain();
        delay_cycles = 32'd20; gptp_rv_ready = 1'b0; gptp_ts_vaild = 1'b1;
        gptp_ts_data = rand_frame(); step(); tx_ns = rtc_nanosec_field;
        gptp_ts_data = rand_frame(); step();
        gptp_ts_vaild = 1'b0;
        for (int i = 0; i < 100 && !gptp_rv_vaild; i++) step();
        chk("bp_entry_ns", gptp_rv_data[FRAME_W +: 32], tx_ns + 32'd20);
        hold = gptp_rv_data;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("bp_valid_held", gptp_rv_vaild, 1);
            chk("bp_data_held", gptp_rv_data, hold);
        end
        chk("bp_second_queued", queue_level, 1);
        drain();

        // Head-of-line: short-delay B waits behind long-delay A.
        fa = rand_frame(); fb = rand_frame();
        gptp_rv_ready = 1'b1; delay_cycles = 32'd100; gptp_ts_data = fa; gptp_ts_vaild = 1'b1;
        step();
        gptp_ts_vaild = 1'b0;
        repeat (4) step();
        delay_cycles = 32'd10; gptp_ts_data = fb; gptp_ts_vaild = 1'b1;
        step();
        gptp_ts_vaild = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            step();
            if (gptp_rv_vaild) lat = k;
        end
        chk("hol_a_first", gptp_rv_data[FRAME_W-1:0], fa);
        chk("hol_a_time", lat, 95);
        step();
        chk("hol_b_valid", gptp_rv_vaild, 1);
        chk("hol_b_next", gptp_rv_data[FRAME_W-1:0], fb);
        drain();

        // Counter wrap on the 8-bit instance: accept at cnt=200, due wraps to 44.
        for (int i = 0; i < 300 && (m_cnt % 256) != 200; i++) step();
        w_dly = 8'd100; w_v = 1'b1; fa = rand_frame(); gptp_ts_data = fa;
        step();
        tx_ns = rtc_nanosec_field;
        w_v = 1'b0;
        lat = 0;
        for (int k = 1; k <= 300 && lat == 0; k++) begin
            step();
            if (w_rv_v) lat = k;
        end
        chk("wrap_latency", lat, 100);
        chk("wrap_rx_ns", w_rv_d[FRAME_W +: 32], tx_ns + 32'd100);
        chk("wrap_frame", w_rv_d[FRAME_W-1:0], fa);
        step();
        chk("wrap_sent", w_sent, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            gptp_ts_vaild = ($urandom_range(0, 2) != 0);
            gptp_ts_data  = rand_frame();
            delay_cycles  = $urandom_range(0, 12);
            gptp_rv_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset with frames in flight.
        drain();
        gptp_rv_ready = 1'b0; delay_cycles = 32'd2; gptp_ts_vaild = 1'b1;
        repeat (4) begin
            gptp_ts_data = rand_frame();
            step();
        end
        gptp_ts_vaild = 1'b0;
        chk("pre_rst_level", queue_level, 3);
        chk("pre_rst_valid", gptp_rv_vaild, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_rv_vaild", gptp_rv_vaild, 0);
        chk("arst_ts_rv_vaild", gptp_ts_rv_vaild, 0);
        chk("arst_level", queue_level, 0);
        chk("arst_sent", frames_sent, 0);
        chk("arst_ready", gptp_ts_ready, 0);
        model_reset();
        repeat (2) step();
        #1 reset = 1'b1;
        #1 chk("release_ready_pre_edge", gptp_ts_ready, 0);
        gptp_rv_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            gptp_ts_vaild = ($urandom_range(0, 3) == 0);
            gptp_ts_data  = rand_frame();
            delay_cycles  = $urandom_range(0, 8);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
